// File: rtl/cu_xbar_rf.sv
// cu_xbar_rf: combined write crossbar, writeback stage and dual-read register file.
// One write per cycle is chosen from the bus-connect port or the FU result channels.
// It is staged in a writeback register and committed to the array one edge later.
// The optional macro CU_XB_BYPASS_EN adds read forwarding from the current write
// select and from the writeback stage. Without it, reads see array contents only.
module cu_xbar_rf #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 4,
   parameter int NUM_FU        = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stall,
   input  logic [NUM_FU-1:0]            ps_xb_w_cuEn,
   input  logic                         ps_xb_w_bcEn,
   input  logic [ADDRESS_WIDTH-1:0]     ps_xb_wadd,
   input  logic [ADDRESS_WIDTH-1:0]     ps_xb_raddx,
   input  logic [ADDRESS_WIDTH-1:0]     ps_xb_raddy,
   input  logic [DATA_WIDTH-1:0]        bc_dt,
   input  logic [NUM_FU*DATA_WIDTH-1:0] fu_xb_dt,
   output logic [DATA_WIDTH-1:0]        xb_dtx,
   output logic [DATA_WIDTH-1:0]        xb_dty,
   output logic                         xb_ps_wcnf,
   output logic                         xb_ps_wbusy
);

   localparam int DEPTH = 2**ADDRESS_WIDTH;

   // Register-file array; deliberately not reset.
   logic [DATA_WIDTH-1:0]    rf_q [DEPTH];

   logic                     wb_vld_q, wb_vld_d;
   logic [ADDRESS_WIDTH-1:0] wb_add_q, wb_add_d;
   logic [DATA_WIDTH-1:0]    wb_dt_q,  wb_dt_d;
   logic [DATA_WIDTH-1:0]    dtx_q,    dtx_d;
   logic [DATA_WIDTH-1:0]    dty_q,    dty_d;
   logic                     wcnf_q,   wcnf_d;

   logic                     wsel_vld;
   logic [DATA_WIDTH-1:0]    wsel_dt;
   logic                     wsel_cnf;
   logic [NUM_FU:0]          wen_all;
   logic [DATA_WIDTH-1:0]    rd_x, rd_y;

   // Write source select: bus connect first, then lowest-index FU channel.
   always_comb begin
      wsel_vld = 1'b0;
      wsel_dt  = '0;
      if (ps_xb_w_bcEn) begin
         wsel_vld = 1'b1;
         wsel_dt  = bc_dt;
      end else begin
         for (int i = NUM_FU-1; i >= 0; i--) begin
            if (ps_xb_w_cuEn[i]) begin
               wsel_vld = 1'b1;
               wsel_dt  = fu_xb_dt[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   // Conflict when more than one enable is set (clearing the lowest set bit leaves a bit).
   always_comb begin
      wen_all  = {ps_xb_w_cuEn, ps_xb_w_bcEn};
      wsel_cnf = |(wen_all & (wen_all - 1'b1));
   end

   // Read data for both ports, forwarding the newest pending value when enabled.
   always_comb begin
`ifdef CU_XB_BYPASS_EN
      if (wsel_vld && (ps_xb_wadd == ps_xb_raddx))     rd_x = wsel_dt;
      else if (wb_vld_q && (wb_add_q == ps_xb_raddx))  rd_x = wb_dt_q;
      else                                             rd_x = rf_q[ps_xb_raddx];
      if (wsel_vld && (ps_xb_wadd == ps_xb_raddy))     rd_y = wsel_dt;
      else if (wb_vld_q && (wb_add_q == ps_xb_raddy))  rd_y = wb_dt_q;
      else                                             rd_y = rf_q[ps_xb_raddy];
`else
      rd_x = rf_q[ps_xb_raddx];
      rd_y = rf_q[ps_xb_raddy];
`endif
   end

   // Next state: everything holds while stalled; otherwise load write, flag and operands.
   always_comb begin
      wb_vld_d = wb_vld_q;
      wb_add_d = wb_add_q;
      wb_dt_d  = wb_dt_q;
      wcnf_d   = wcnf_q;
      dtx_d    = dtx_q;
      dty_d    = dty_q;
      if (!stall) begin
         wb_vld_d = wsel_vld;
         if (wsel_vld) begin
            wb_add_d = ps_xb_wadd;
            wb_dt_d  = wsel_dt;
         end
         wcnf_d = wsel_cnf;
         dtx_d  = rd_x;
         dty_d  = rd_y;
      end
   end

   // Pipeline registers; reset drops any pending writeback entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_vld_q <= 1'b0;
         wb_add_q <= '0;
         wb_dt_q  <= '0;
         wcnf_q   <= 1'b0;
         dtx_q    <= '0;
         dty_q    <= '0;
      end else begin
         wb_vld_q <= wb_vld_d;
         wb_add_q <= wb_add_d;
         wb_dt_q  <= wb_dt_d;
         wcnf_q   <= wcnf_d;
         dtx_q    <= dtx_d;
         dty_q    <= dty_d;
      end
   end

   // Commit the writeback entry to the array on the first unstalled edge after loading.
   always_ff @(posedge clk) begin
      if (!stall && wb_vld_q) rf_q[wb_add_q] <= wb_dt_q;
   end

   assign xb_dtx      = dtx_q;
   assign xb_dty      = dty_q;
   assign xb_ps_wcnf  = wcnf_q;
   assign xb_ps_wbusy = wb_vld_q;

endmodule

// File: tb/tb_cu_xbar_rf.sv
// tb_cu_xbar_rf: directed bench for cu_xbar_rf with a write-history reference model.
// Build with +define+CU_XB_BYPASS_EN to exercise the forwarding configuration.
module tb_cu_xbar_rf;
   localparam int DW = 16;
   localparam int AW = 4;
   localparam int NF = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic              stall = 1'b0;
   logic [NF-1:0]     cu_en = '0;
   logic              bc_en = 1'b0;
   logic [AW-1:0]     wadd = '0, raddx = '0, raddy = '0;
   logic [DW-1:0]     bc_dt = '0;
   logic [NF*DW-1:0]  fu_dt = '0;
   logic [DW-1:0]     dtx, dty;
   logic              wcnf, wbusy;

   cu_xbar_rf #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_FU(NF)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .ps_xb_w_cuEn (cu_en),
      .ps_xb_w_bcEn (bc_en),
      .ps_xb_wadd   (wadd),
      .ps_xb_raddx  (raddx),
      .ps_xb_raddy  (raddy),
      .bc_dt        (bc_dt),
      .fu_xb_dt     (fu_dt),
      .xb_dtx       (dtx),
      .xb_dty       (dty),
      .xb_ps_wcnf   (wcnf),
      .xb_ps_wbusy  (wbusy)
   );

   // ---------------- reference model ----------------
   // Every accepted write is logged with the index of the unstalled cycle that issued it.
   // A read issued in unstalled cycle n sees the newest logged write to its address
   // issued no later than n (forwarding) or n-2 (array only).
   typedef struct {
      int            cyc;
      logic [AW-1:0] add;
      logic [DW-1:0] dt;
   } wr_t;
   wr_t hist[$];
   int  acyc = 0;

   logic [DW-1:0] exp_x = '0, exp_y = '0;
   logic          exp_x_vld = 1'b1, exp_y_vld = 1'b1;
   logic          exp_wcnf = 1'b0, exp_busy = 1'b0;
   logic          chk_en = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   function automatic logic lookup(input logic [AW-1:0] a, input int lim, output logic [DW-1:0] d);
      logic found = 1'b0;
      d = '0;
      foreach (hist[i]) begin
         if (hist[i].add == a && hist[i].cyc <= lim) begin
            d = hist[i].dt;
            found = 1'b1;
         end
      end
      return found;
   endfunction

   task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         if (exp_x_vld) check("model_dtx", dtx, exp_x);
         if (exp_y_vld) check("model_dty", dty, exp_y);
         check("model_wcnf", {15'b0, wcnf}, {15'b0, exp_wcnf});
         check("model_wbusy", {15'b0, wbusy}, {15'b0, exp_busy});
      end
   end

   // ---------------- driver ----------------
   // Apply one cycle of inputs, wait for the edge, then advance the model.
   task automatic drive(input logic st, input logic bc, input logic [NF-1:0] cu,
                        input logic [AW-1:0] wa, input logic [AW-1:0] rx, input logic [AW-1:0] ry,
                        input logic [DW-1:0] bd, input logic [NF*DW-1:0] fu);
      logic          has_w;
      logic [DW-1:0] wd;
      int            n_en, lim;
      stall = st; bc_en = bc; cu_en = cu; wadd = wa;
      raddx = rx; raddy = ry; bc_dt = bd; fu_dt = fu;
      @(posedge clk);
      if (!st) begin
         has_w = 1'b0;
         wd    = '0;
         n_en  = (bc ? 1 : 0) + $countones(cu);
         if (bc) begin
            has_w = 1'b1;
            wd    = bd;
         end else begin
            for (int i = 0; i < NF; i++) begin
               if (cu[i] && !has_w) begin
                  has_w = 1'b1;
                  wd    = fu[i*DW +: DW];
               end
            end
         end
         if (has_w) hist.push_back('{cyc: acyc, add: wa, dt: wd});
`ifdef CU_XB_BYPASS_EN
         lim = acyc;
`else
         lim = acyc - 2;
`endif
         exp_x_vld = lookup(rx, lim, exp_x);
         exp_y_vld = lookup(ry, lim, exp_y);
         exp_wcnf  = (n_en > 1);
         exp_busy  = has_w;
         acyc++;
      end
      #1;
   endtask

   task automatic idle(input logic [AW-1:0] rx, input logic [AW-1:0] ry);
      drive(1'b0, 1'b0, '0, '0, rx, ry, '0, '0);
   endtask

   task automatic wr_bc(input logic [AW-1:0] wa, input logic [DW-1:0] d, input logic [AW-1:0] rx, input logic [AW-1:0] ry);
      drive(1'b0, 1'b1, '0, wa, rx, ry, d, '0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // reset state
      #1;
      check("rst_dtx", dtx, 16'h0000);
      check("rst_dty", dty, 16'h0000);
      check("rst_wcnf", {15'b0, wcnf}, 16'h0000);
      check("rst_wbusy", {15'b0, wbusy}, 16'h0000);
      @(posedge clk); #3;
      reset = 1'b1;
      chk_en = 1'b1;

      // give every register a known value: reg i = 0xC000 | i
      for (int i = 0; i < 16; i++) wr_bc(AW'(i), 16'hC000 | DW'(i), AW'(i), AW'(15 - i));
      idle(0, 1);
      idle(2, 3);

      // write-then-read of reg 5
      wr_bc(5, 16'h1234, 0, 0);
      idle(5, 5);
`ifdef CU_XB_BYPASS_EN
      check("wtr_bypass_n1", dtx, 16'h1234);
`else
      check("wtr_nobypass_n1", dtx, 16'hC005);
`endif
      idle(5, 0);
      check("wtr_n2", dtx, 16'h1234);

      // FU select: only channel 2 is written
      drive(1'b0, 1'b0, 3'b100, 2, 0, 0, '0, {16'hBEEF, 16'h5555, 16'hAAAA});
      idle(0, 0);
      idle(0, 0);
      idle(0, 2);
      check("fu_sel_ch2", dty, 16'hBEEF);

      // conflict: bus connect beats FU channels
      drive(1'b0, 1'b1, 3'b011, 7, 0, 0, 16'h0F0F, {16'h0000, 16'h5555, 16'hAAAA});
      check("cnf_set", {15'b0, wcnf}, 16'h0001);
      idle(0, 0);
      check("cnf_one_cycle", {15'b0, wcnf}, 16'h0000);
      idle(7, 7);
      check("cnf_bc_wins", dtx, 16'h0F0F);
      drive(1'b0, 1'b0, 3'b011, 7, 0, 0, '0, {16'h0000, 16'h2468, 16'h1357});
      check("cnf_fu_pair", {15'b0, wcnf}, 16'h0001);
      idle(0, 0);
      idle(0, 0);
      idle(0, 7);
      check("cnf_ch0_wins", dty, 16'h1357);

      // stall: pending write to reg 3 held, writes presented during stall ignored
      wr_bc(3, 16'h3333, 1, 1);
      drive(1'b1, 1'b1, '0, 3, 3, 11, 16'h9999, '0);
      check("stall_busy0", {15'b0, wbusy}, 16'h0001);
      check("stall_hold_x0", dtx, 16'hC001);
      drive(1'b1, 1'b0, 3'b001, 11, 11, 3, '0, {16'h0, 16'h0, 16'h7777});
      check("stall_busy1", {15'b0, wbusy}, 16'h0001);
      drive(1'b1, 1'b1, 3'b110, 3, 3, 3, 16'h8888, {16'h6666, 16'h6666, 16'h0});
      check("stall_busy2", {15'b0, wbusy}, 16'h0001);
      check("stall_hold_y2", dty, 16'hC001);
      idle(3, 11);
`ifdef CU_XB_BYPASS_EN
      check("stall_release_fwd", dtx, 16'h3333);
`else
      check("stall_release_arr", dtx, 16'hC003);
`endif
      check("stall_release_busy", {15'b0, wbusy}, 16'h0000);
      idle(3, 11);
      check("stall_commit", dtx, 16'h3333);
      check("stall_ignored", dty, 16'hC00B);

      // same-address chain on reg 9
      wr_bc(9, 16'h0011, 9, 9);
`ifdef CU_XB_BYPASS_EN
      check("chain_0", dtx, 16'h0011);
`endif
      wr_bc(9, 16'h0022, 9, 9);
`ifdef CU_XB_BYPASS_EN
      check("chain_1", dtx, 16'h0022);
`endif
      wr_bc(9, 16'h0033, 9, 9);
`ifdef CU_XB_BYPASS_EN
      check("chain_2", dtx, 16'h0033);
`endif
      idle(0, 0);
      idle(0, 0);
      idle(9, 9);
      check("chain_final", dtx, 16'h0033);

      // reset with a pending write to reg 4: the write is lost
      wr_bc(4, 16'hDEAD, 0, 0);
      check("rst_pre_busy", {15'b0, wbusy}, 16'h0001);
      #2;
      reset = 1'b0;
      chk_en = 1'b0;
      bc_en = 1'b0; cu_en = '0; stall = 1'b0;
      #1;
      check("arst_dtx", dtx, 16'h0000);
      check("arst_dty", dty, 16'h0000);
      check("arst_wcnf", {15'b0, wcnf}, 16'h0000);
      check("arst_wbusy", {15'b0, wbusy}, 16'h0000);
      for (int i = hist.size() - 1; i >= 0; i--) if (hist[i].cyc >= acyc - 1) hist.delete(i);
      exp_x = '0; exp_y = '0; exp_x_vld = 1'b1; exp_y_vld = 1'b1;
      exp_wcnf = 1'b0; exp_busy = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      chk_en = 1'b1;
      idle(0, 0);
      idle(0, 0);
      idle(4, 4);
      check("rst_lost_x", dtx, 16'hC004);
      check("rst_lost_y", dty, 16'hC004);
      idle(4, 5);
      check("rst_lost_again", dtx, 16'hC004);
      idle(0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
